vector_sequencer: RTL
=====================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8, meaning coordinate width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning vector-list address width.
REQ-003 SHALL have parameter POS_WAIT, default 2, meaning cycles to hold after a pos pulse before the next fetch.
REQ-004 SHALL have port clk  in  1  system clock; one clock, all logic on posedge clk.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to traverse the list from address 0.
REQ-007 SHALL have port loop  in  1  when high, restart automatically at frame end.
REQ-008 SHALL have port rom_addr  out  ADDR_WIDTH  vector-list read address.
REQ-009 SHALL have port rom_data  in  2+2*OUT_WIDTH  entry {op[1:0], x, y}, valid one cycle after rom_addr.
REQ-010 SHALL have port pos  out  1  one-cycle move-cursor command to the line drawer.
REQ-011 SHALL have port draw  out  1  one-cycle draw-line command to the line drawer.
REQ-012 SHALL have ports x_start, y_start  out  OUT_WIDTH  current cursor (line origin).
REQ-013 SHALL have ports x_end, y_end  out  OUT_WIDTH  target point of current command.
REQ-014 SHALL have port draw_done  in  1  completion pulse from the line drawer.
REQ-015 SHALL have port busy  out  1  high from accepted start until return to IDLE.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse at end of each traversal.
REQ-017 SHALL have port error  out  1  sticky draw-timeout flag.

Function
REQ-018 SHALL decode op: 00 MOVE, 01 LINE, 10 END, 11 NOP.
REQ-019 SHALL implement states IDLE, FETCH, DECODE, ISSUE, WAIT_POS, WAIT_DRAW, FRAME_END.
REQ-020 IDLE->FETCH on start; start while busy SHALL be ignored.
REQ-021 FETCH SHALL drive rom_addr and go to DECODE next cycle; DECODE SHALL register x_end/y_end from rom_data.
REQ-022 MOVE: ISSUE SHALL pulse pos for exactly one cycle, then WAIT_POS for POS_WAIT cycles, then cursor <= end, addr+1, FETCH.
REQ-023 LINE: ISSUE SHALL pulse draw for exactly one cycle with x_start/y_start/x_end/y_end stable from ISSUE until draw_done.
REQ-024 WAIT_DRAW SHALL hold until draw_done=1, then cursor <= end, addr+1, FETCH.
REQ-025 draw_done arriving in the same cycle as the draw pulse SHALL be ignored.
REQ-026 NOP SHALL advance addr and go to FETCH without pos/draw; latency 2 cycles per NOP.
REQ-027 END, or reaching address 2^ADDR_WIDTH-1 after executing it, SHALL go to FRAME_END (no wrap to 0 mid-frame).
REQ-028 FRAME_END SHALL pulse frame_done one cycle, then go to FETCH at addr 0 if loop=1, else IDLE.
REQ-029 pos and draw SHALL never be high in the same cycle.
REQ-030 Outputs SHALL change only on posedge clk (all registered).

Reset
REQ-031 On rst: state IDLE, rom_addr 0, pos/draw/busy/frame_done/error 0, cursor and x_end/y_end 0.
REQ-032 Reset mid-frame SHALL abandon the command immediately; no draw_done is awaited.

Configuration
REQ-033 Macro VECTOR_SEQ_TIMEOUT_EN SHALL, when defined, add a counter in WAIT_DRAW; after 1024 cycles without draw_done, set error, go to FRAME_END.
REQ-034 Without VECTOR_SEQ_TIMEOUT_EN, WAIT_DRAW SHALL wait indefinitely and error SHALL be constant 0.

Structure
REQ-035 Package vector_pkg SHALL hold the op enum, state enum and timeout constant.
REQ-036 No sub-module; the ROM is external.

Verification
REQ-037 List {MOVE(10,20), LINE(50,20), END}, start -> pos once with end (10,20); then draw with start (10,20) end (50,20); frame_done after draw_done.
REQ-038 Drawer stub delays draw_done 300 cycles -> draw held as single pulse, coordinates stable, no refetch before draw_done.
REQ-039 NOP at addr 1, loop=1 -> NOP skipped, frame_done each pass, rom_addr returns to 0.
REQ-040 rst asserted in WAIT_DRAW -> next cycle IDLE, all outputs 0, later draw_done ignored.
REQ-041 VECTOR_SEQ_TIMEOUT_EN, draw_done never -> error=1 at cycle 1024, frame_done pulse, error sticky until rst.
REQ-042 List full of LINE with no END (ADDR_WIDTH=4) -> 16 draws then frame_done, no wrap.

Source files
------------

// File: rtl/vector_pkg.sv
// vector_pkg: op/state encodings and draw-timeout length shared by the vector sequencer
package vector_pkg;
  typedef enum logic [1:0] {OP_MOVE, OP_LINE, OP_END, OP_NOP} op_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_POS, S_WAIT_DRAW, S_FRAME_END} state_e;
  localparam int TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/vector_sequencer.sv
// vector_sequencer: walks an external vector list issuing pos/draw commands; VECTOR_SEQ_TIMEOUT_EN adds a draw timeout
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int POS_WAIT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     loop,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  input  logic [2*OUT_WIDTH+1:0]   rom_data,
  output logic                     pos,
  output logic                     draw,
  output logic [OUT_WIDTH-1:0]     x_start,
  output logic [OUT_WIDTH-1:0]     y_start,
  output logic [OUT_WIDTH-1:0]     x_end,
  output logic [OUT_WIDTH-1:0]     y_end,
  input  logic                     draw_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     error
);
  state_e state, next;
  op_e op, rom_op;
  logic [31:0] cnt;
  logic last, timeout, pos_d, draw_d, adv_cur, adv, restart;
  assign rom_op = op_e'(rom_data[2*OUT_WIDTH+1 -: 2]);
  assign last = &rom_addr;
`ifdef VECTOR_SEQ_TIMEOUT_EN
  assign timeout = state == S_WAIT_DRAW && !draw_done && cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) error <= 1'b0;
    else if (timeout) error <= 1'b1;
`else
  assign timeout = 1'b0;
  assign error = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= OP_MOVE;
      cnt        <= '0;
      rom_addr   <= '0;
      pos        <= 1'b0;
      draw       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      x_start    <= '0;
      y_start    <= '0;
      x_end      <= '0;
      y_end      <= '0;
    end else begin
      state      <= next;
      cnt        <= next != state ? '0 : cnt + 32'd1;
      pos        <= pos_d;
      draw       <= draw_d;
      busy       <= next != S_IDLE;
      frame_done <= next == S_FRAME_END;
      if (state == S_DECODE) begin
        op    <= rom_op;
        x_end <= rom_data[2*OUT_WIDTH-1 -: OUT_WIDTH];
        y_end <= rom_data[OUT_WIDTH-1:0];
      end
      if (adv_cur) begin
        x_start <= x_end;
        y_start <= y_end;
      end
      // the last address ends the frame instead of wrapping to 0
      if (restart) rom_addr <= '0;
      else if (adv && !last) rom_addr <= rom_addr + ADDR_WIDTH'(1);
    end
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:      next = start ? S_FETCH : S_IDLE;
      S_FETCH:     next = S_DECODE;
      S_DECODE:    next = rom_op == OP_END ? S_FRAME_END :
                          rom_op == OP_NOP ? (last ? S_FRAME_END : S_FETCH) : S_ISSUE;
      S_ISSUE:     next = op == OP_MOVE ? S_WAIT_POS : S_WAIT_DRAW;
      S_WAIT_POS:  next = cnt + 32'd1 >= 32'(POS_WAIT) ? (last ? S_FRAME_END : S_FETCH) : S_WAIT_POS;
      S_WAIT_DRAW: next = timeout ? S_FRAME_END : draw_done ? (last ? S_FRAME_END : S_FETCH) : S_WAIT_DRAW;
      S_FRAME_END: next = loop ? S_FETCH : S_IDLE;
      default:     next = S_IDLE;
    endcase
  end
  always_comb begin
    pos_d   = state == S_DECODE && rom_op == OP_MOVE;
    draw_d  = state == S_DECODE && rom_op == OP_LINE;
    adv_cur = (state == S_WAIT_POS && next != S_WAIT_POS) || (state == S_WAIT_DRAW && draw_done && !timeout);
    adv     = adv_cur || (state == S_DECODE && rom_op == OP_NOP);
    restart = (state == S_IDLE && start) || (state == S_FRAME_END && loop);
  end
endmodule
